sr_bank_scheduler: RTL

Round-robin scheduler that shares one bank of WIDTH SR flip-flops (S/R inputs, Q feedback) among NREQ requesters. Each requester asks to set or reset one bit. The block grants one request at a time, drives a single-cycle S or R pulse into the bank and checks the resulting Q. It guarantees the bank never sees S=R=1 on any bit and never sees more than one active bit.

---
 rtl/sr_ctrl_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 39 +++
 rtl/sr_bank_scheduler.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/sr_ctrl_pkg.sv
// Shared definitions for the SR bank scheduler.
//   state_t  : FSM encoding (ST_IDLE, ST_DRIVE, ST_CHECK)
//   OP_RESET : request clears the target bit
//   OP_SET   : request sets the target bit
package sr_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    localparam logic OP_RESET = 1'b0;
    localparam logic OP_SET   = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. Searches upward from ptr, wrapping
// modulo NREQ, and returns the first asserted request.
// Ports:
//   req     in   NREQ  pending requests
//   ptr     in   IW    highest-priority requester (held by the parent)
//   en      in   1     arbitration enable; no grant when low
//   gnt     out  NREQ  one-hot grant
//   gnt_idx out  IW    binary index of the granted requester
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = 3
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx
);

    always_comb begin
        int  j;
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        j       = 0;
        if (en) begin
            for (int k = 0; k < NREQ; k++) begin
                j = (int'(ptr) + k) % NREQ;
                if (!found && req[j]) begin
                    found   = 1'b1;
                    gnt[j]  = 1'b1;
                    gnt_idx = IW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/sr_bank_scheduler.sv
// Round-robin scheduler sharing one bank of WIDTH SR flip-flops among NREQ
// requesters. One request at a time: a single-cycle S or R pulse, then a
// check of the fed-back Q. S and R are never both active and at most one
// bit is ever driven.
// Ports:
//   clk, rst   clock (rising edge), async active-high reset
//   req_valid  in   NREQ       pending request per requester
//   req_op     in   NREQ       1 = set, 0 = reset
//   req_idx    in   NREQ*IDXW  target bit, requester i at [i*IDXW +: IDXW]
//   q          in   WIDTH      bank Q feedback
//   req_ready  out  NREQ       one-hot completion pulse
//   req_err    out  1          valid with req_ready; Q mismatch or bad index
//   s, r       out  WIDTH      bank S/R drive
//   busy       out  1          not in IDLE
//   grant_id   out  IDXW       current/last granted requester
//
// state    | meaning
// ST_IDLE  | arbitrating; grant latched on the edge leaving this state
// ST_DRIVE | one-cycle S or R pulse on the latched bit
// ST_CHECK | req_ready to the grantee, req_err from live Q
module sr_bank_scheduler
    import sr_ctrl_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDXW  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_op,
    input  logic [NREQ*IDXW-1:0] req_idx,
    input  logic [WIDTH-1:0]     q,
    output logic [NREQ-1:0]      req_ready,
    output logic                 req_err,
    output logic [WIDTH-1:0]     s,
    output logic [WIDTH-1:0]     r,
    output logic                 busy,
    output logic [IDXW-1:0]      grant_id
);

    state_t            state, state_nx;
    logic [IDXW-1:0]   ptr;
    logic [IDXW-1:0]   g_r;
    logic [IDXW-1:0]   idx_r;
    logic              op_r;
    logic              ferr_r;

    logic [NREQ-1:0]   gnt;
    logic [IDXW-1:0]   gnt_idx;
    logic              any_req;
    logic [IDXW-1:0]   win_idx;
    logic              win_op;
    logic              win_rng;
    logic              win_qbit;
    logic              cur_qbit;
    logic [WIDTH-1:0]  bit_oh;
    logic [NREQ-1:0]   rdy_oh;

    assign any_req  = |req_valid;
    assign grant_id = g_r;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IDXW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .en      (state == ST_IDLE),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Winner's op/idx and the Q bit it targets, used for the skip decision.
    always_comb begin
        win_idx  = '0;
        win_op   = OP_RESET;
        win_qbit = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                win_idx = req_idx[i*IDXW +: IDXW];
                win_op  = req_op[i];
            end
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (win_idx == IDXW'(i)) win_qbit = q[i];
        end
    end

    // Range check only exists when the index can address past the bank.
    generate
        if ((1 << IDXW) > WIDTH) begin : g_rng
            assign win_rng = ({1'b0, win_idx} < (IDXW+1)'(WIDTH));
        end else begin : g_full
            assign win_rng = 1'b1;
        end
    endgenerate

    // Latched-bit decode: S/R one-hot, live Q bit, and ready one-hot.
    always_comb begin
        bit_oh   = '0;
        cur_qbit = 1'b0;
        rdy_oh   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (idx_r == IDXW'(i)) begin
                bit_oh[i] = 1'b1;
                cur_qbit  = q[i];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (g_r == IDXW'(i)) rdy_oh[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        s         = '0;
        r         = '0;
        req_ready = '0;
        req_err   = 1'b0;
        busy      = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    if (!win_rng || (win_qbit == win_op)) state_nx = ST_CHECK;
                    else                                  state_nx = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (op_r == OP_SET) s = bit_oh;
                else                r = bit_oh;
                state_nx = ST_CHECK;
            end
            ST_CHECK: begin
                req_ready = rdy_oh;
                req_err   = ferr_r | (cur_qbit != op_r);
                state_nx  = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr    <= '0;
            g_r    <= '0;
            idx_r  <= '0;
            op_r   <= OP_RESET;
            ferr_r <= 1'b0;
        end else if (state == ST_IDLE && any_req) begin
            g_r    <= gnt_idx;
            idx_r  <= win_idx;
            op_r   <= win_op;
            ferr_r <= !win_rng;
            ptr    <= (gnt_idx == IDXW'(NREQ-1)) ? '0 : gnt_idx + IDXW'(1);
        end
    end

endmodule
